// File: rtl/bus_pkg.sv
`default_nettype none
// bus_pkg: shared definitions for the core memory bus responder.
// Beat-state encoding, bus data width and parameter limits.
package bus_pkg;

    localparam int BUS_DW              = 32;
    localparam int CNT_W               = 4;
    localparam int DEFAULT_WAIT_STATES = 1;
    localparam int MAX_NMASTERS        = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } beat_state_t;

endpackage
`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
`default_nettype none
// bus_rr_arbiter: registered one-hot grant with owner hold and round-robin
// hand-over starting from the slot after the last owner.
module bus_rr_arbiter #(
    parameter int NMASTERS = 2
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic [NMASTERS-1:0] req,
    output logic [NMASTERS-1:0] grant
);
    localparam int PW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;

    logic [PW-1:0]       last_owner;
    logic [PW-1:0]       last_owner_nx;
    logic [PW-1:0]       idx;
    logic [NMASTERS-1:0] grant_nx;
    logic                found;

    always_comb begin
        grant_nx      = '0;
        last_owner_nx = last_owner;
        found         = 1'b0;
        idx           = '0;
        if ((grant & req) != '0) begin
            grant_nx = grant;
        end else begin
            // Highest priority is the slot right after the previous owner.
            for (int i = 1; i <= NMASTERS; i++) begin
                idx = PW'((int'(last_owner) + i) % NMASTERS);
                if (!found && req[idx]) begin
                    found         = 1'b1;
                    grant_nx[idx] = 1'b1;
                    last_owner_nx = idx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            grant      <= '0;
            last_owner <= '0;
        end else begin
            grant      <= grant_nx;
            last_owner <= last_owner_nx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_mem_responder.sv
`default_nettype none
// bus_mem_responder: arbitrates bus initiators and serves single-word
// reads/writes from on-chip RAM with a fixed number of wait states.
module bus_mem_responder
    import bus_pkg::*;
#(
    parameter int NMASTERS    = 2,
    parameter int ADDR_BITS   = 12,
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic [NMASTERS-1:0] bus_req,
    output logic [NMASTERS-1:0] bus_ack,
    input  logic [BUS_DW-1:0]   bus_addr,
    input  logic                bus_rd,
    input  logic                bus_wr,
    input  logic [BUS_DW-1:0]   bus_wdata,
    output logic [BUS_DW-1:0]   bus_rdata,
    output logic                bus_ready
);
    logic [BUS_DW-1:0] ram [0:(1<<ADDR_BITS)-1];

    beat_state_t       state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [BUS_DW-1:0] addr_l, addr_nx;
    logic              rd_l, rd_nx, wr_l, wr_nx;
    logic              ready_nx;
    logic [BUS_DW-1:0] rdata_nx;
    logic [ADDR_BITS-1:0] rd_idx;
    logic              owner_req, cmd, abort;

    bus_rr_arbiter #(.NMASTERS(NMASTERS)) u_arb (
        .clk   (clk),
        .rst_b (rst_b),
        .req   (bus_req),
        .grant (bus_ack)
    );

    assign owner_req = |(bus_req & bus_ack);
    assign cmd       = owner_req && (bus_rd || bus_wr);
    // Any change of the presented command, or loss of ownership, kills the beat.
    assign abort     = (bus_addr != addr_l) || (bus_rd != rd_l) ||
                       (bus_wr != wr_l) || !owner_req;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        addr_nx  = addr_l;
        rd_nx    = rd_l;
        wr_nx    = wr_l;
        ready_nx = 1'b0;
        rdata_nx = '0;
        rd_idx   = addr_l[ADDR_BITS+1:2];
        case (state)
            S_IDLE: begin
                if (cmd) begin
                    addr_nx = bus_addr;
                    rd_nx   = bus_rd;
                    wr_nx   = bus_wr;
                    cnt_nx  = CNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_nx = S_READY;
                        ready_nx = 1'b1;
                        rd_idx   = bus_addr[ADDR_BITS+1:2];
                    end else begin
                        state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_nx = cnt - 1'b1;
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    state_nx = S_READY;
                    ready_nx = 1'b1;
                end
            end
            S_READY: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        // Read wins when both commands are asserted.
        if (ready_nx && rd_nx) begin
            rdata_nx = ram[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state     <= S_IDLE;
            cnt       <= '0;
            addr_l    <= '0;
            rd_l      <= 1'b0;
            wr_l      <= 1'b0;
            bus_ready <= 1'b0;
            bus_rdata <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            addr_l    <= addr_nx;
            rd_l      <= rd_nx;
            wr_l      <= wr_nx;
            bus_ready <= ready_nx;
            bus_rdata <= rdata_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b && state == S_READY && wr_l && !rd_l && !abort) begin
            ram[addr_l[ADDR_BITS+1:2]] <= bus_wdata;
        end
    end

endmodule
`default_nettype wire
